vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch widths in pixels; H_TOTAL = sum = 800.
REQ-003 Parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical equivalents in lines; V_TOTAL = 525.
REQ-004 Parameter SYNC_POL, default 0, asserted level of hsync/vsync (0 = active-low).
REQ-005 Parameter PIPE, default 2, range 0..7, cycles by which hsync/vsync/de lag x/y/req, matching downstream pixel-generator latency.
REQ-006 clkp  in  1  pixel clock (25 MHz); the only clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 x  out  10  current horizontal counter value.
REQ-009 y  out  10  current vertical counter value.
REQ-010 req  out  1  high when (x,y) is inside the active area; the pixel generator is expected to fetch this pixel.
REQ-011 line_start  out  1  one-cycle pulse when x = 0.
REQ-012 frame_start  out  1  one-cycle pulse when x = 0 and y = 0.
REQ-013 hsync, vsync, de  out  1 each  sync and data-enable for vga2tmds, delayed PIPE cycles.

Function
REQ-014 Internal registers hcnt (0..H_TOTAL-1), vcnt (0..V_TOTAL-1) and a running flag; counters advance only while running = 1.
REQ-015 hcnt increments every running cycle; at H_TOTAL-1 it wraps to 0 and vcnt increments in the same cycle.
REQ-016 vcnt wraps from V_TOTAL-1 to 0 exactly when hcnt wraps on line V_TOTAL-1.
REQ-017 x = hcnt, y = vcnt, combinationally from the registers; zero while running = 0.
REQ-018 Raw active = running and hcnt < H_ACTIVE and vcnt < V_ACTIVE; req = raw active.
REQ-019 Raw hsync asserted (level SYNC_POL) when running and H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751 default); else ~SYNC_POL.
REQ-020 Raw vsync asserted when running and V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491 default); vsync changes only together with hcnt wrapping to 0.
REQ-021 line_start and frame_start are gated by running; they never assert during reset.
REQ-022 hsync/vsync/de at cycle n equal raw hsync/vsync/active at cycle n-PIPE; PIPE = 0 gives zero-latency passthrough.
REQ-023 Delay line shifts every cycle regardless of running; no bubbles or stalls.
REQ-024 Timing is free-running; there is no external stall or handshake input.

Reset
REQ-025 With reset high at a clkp edge: hcnt = 0, vcnt = 0, running = 0, every delay stage = {hsync ~SYNC_POL, vsync ~SYNC_POL, de 0}.
REQ-026 Outputs during reset: x = 0, y = 0, req = 0, line_start = 0, frame_start = 0, hsync = vsync = ~SYNC_POL, de = 0.
REQ-027 First edge with reset low sets running = 1 with counters still 0, so the next cycle presents x = 0, y = 0, frame_start = 1, req = 1.
REQ-028 Reset asserted mid-frame forces the reset state at the next edge; the delay line is flushed, not drained, so no partial sync pulse survives.

Structure
REQ-029 Package vga_timing_pkg holds the 640x480@60 localparams (active, porch, sync, totals) and the counter width constant (10).
REQ-030 One sub-module, sync_delay: parameterised PIPE-deep 3-bit shift register with synchronous reset value input.
REQ-031 Counters and decoding live in vga_timing itself; no other sub-modules.

Verification
REQ-032 Reset 5 cycles, release -> first post-release cycle x=0,y=0,frame_start=1,req=1; de rises exactly PIPE(=2) cycles later.
REQ-033 Run one full frame -> exactly 420000 cycles between frame_start pulses, 800 between line_start pulses, 307200 de-high cycles per frame.
REQ-034 Check line 0 -> hsync low for hcnt 656..751 (96 cycles), delayed 2 cycles; high elsewhere; vsync low only on lines 490..491 (1600 cycles).
REQ-035 Observe hcnt 799 on vcnt 524 -> next cycle x=0,y=0,frame_start=1, vsync unchanged high.
REQ-036 Assert reset for 1 cycle at x=700,y=491 (sync active) -> next cycle hsync=vsync=1, de=0, x=y=0; frame restarts cleanly.
REQ-037 Rebuild with PIPE=0, SYNC_POL=1 -> de coincides with req, hsync high on hcnt 656..751, idle level 0 during reset.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared constants and types for the VGA timing generator.
//   - 640x480@60 default timing (active, porches, sync widths, totals)
//   - CNT_W: width of the x/y counters
//   - sync_t: the {hsync, vsync, de} bundle carried through the delay line
//   - sync_idle(): inactive value of that bundle for a given sync polarity
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int P_H_ACTIVE = 640;
  localparam int P_H_FP     = 16;
  localparam int P_H_SYNC   = 96;
  localparam int P_H_BP     = 48;
  localparam int P_H_TOTAL  = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;  // 800

  localparam int P_V_ACTIVE = 480;
  localparam int P_V_FP     = 10;
  localparam int P_V_SYNC   = 2;
  localparam int P_V_BP     = 33;
  localparam int P_V_TOTAL  = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;  // 525

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  // Idle bundle: both syncs deasserted, no data enable.
  function automatic sync_t sync_idle(input logic pol);
    sync_t s;
    s.hs = ~pol;
    s.vs = ~pol;
    s.de = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/vga_timing_sync_delay.sv
// sync_delay: PIPE-deep shift register for the {hsync, vsync, de} bundle.
//   clkp      in   pixel clock
//   reset     in   synchronous active-high reset; loads every stage with i_rst_val
//   i_rst_val in   value every stage takes during reset
//   i_d       in   raw bundle
//   o_q       out  bundle delayed by PIPE cycles (PIPE = 0: combinational passthrough)
// Reset flushes all stages at once so no partial sync pulse leaks out afterwards.
module sync_delay
  import vga_timing_pkg::*;
#(
  parameter int PIPE = 2
) (
  input  logic  clkp,
  input  logic  reset,
  input  sync_t i_rst_val,
  input  sync_t i_d,
  output sync_t o_q
);

  if (PIPE == 0) begin : g_pass
    // Clock, reset and reset value are not needed without storage.
    logic w_unused;
    assign w_unused = &{1'b0, clkp, reset, i_rst_val};
    assign o_q = i_d;
  end else begin : g_pipe
    sync_t [PIPE-1:0] r_pipe;

    always_ff @(posedge clkp) begin
      if (reset) begin
        for (int i = 0; i < PIPE; i++) r_pipe[i] <= i_rst_val;
      end else begin
        r_pipe[0] <= i_d;
        for (int i = 1; i < PIPE; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_q = r_pipe[PIPE-1];
  end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: free-running VGA raster timing generator.
//   clkp        in   pixel clock
//   reset       in   synchronous active-high reset
//   x, y        out  current horizontal / vertical counter (0 while not running)
//   req         out  (x,y) is in the active area; pixel generator fetches it
//   line_start  out  pulse at x = 0
//   frame_start out  pulse at x = 0, y = 0
//   hsync/vsync/de out  sync and data enable, PIPE cycles behind x/y/req
// Counters start one cycle after reset release (running flag) so the first
// visible cycle shows x=0,y=0 with frame_start.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = P_H_ACTIVE,
  parameter int   H_FP     = P_H_FP,
  parameter int   H_SYNC   = P_H_SYNC,
  parameter int   H_BP     = P_H_BP,
  parameter int   V_ACTIVE = P_V_ACTIVE,
  parameter int   V_FP     = P_V_FP,
  parameter int   V_SYNC   = P_V_SYNC,
  parameter int   V_BP     = P_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIPE     = 2
) (
  input  logic             clkp,
  input  logic             reset,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             req,
  output logic             line_start,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic             de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic             r_running;

  always_ff @(posedge clkp) begin
    if (reset) begin
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_running <= 1'b0;
    end else if (!r_running) begin
      // First released edge only arms the counters; they stay at 0.
      r_running <= 1'b1;
    end else if (r_hcnt == H_LAST) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  logic  w_active;
  logic  w_hs_on;
  logic  w_vs_on;
  sync_t w_raw;
  sync_t w_dly;

  assign w_active = r_running && (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_hs_on  = r_running && (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
  // vcnt only moves on the hcnt wrap, so vsync edges align with x = 0.
  assign w_vs_on  = r_running && (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);

  assign w_raw.hs = w_hs_on ? SYNC_POL : ~SYNC_POL;
  assign w_raw.vs = w_vs_on ? SYNC_POL : ~SYNC_POL;
  assign w_raw.de = w_active;

  assign x           = r_running ? r_hcnt : '0;
  assign y           = r_running ? r_vcnt : '0;
  assign req         = w_active;
  assign line_start  = r_running && (r_hcnt == '0);
  assign frame_start = line_start && (r_vcnt == '0);

  sync_delay #(.PIPE(PIPE)) u_sync_delay (
    .clkp      (clkp),
    .reset     (reset),
    .i_rst_val (sync_idle(SYNC_POL)),
    .i_d       (w_raw),
    .o_q       (w_dly)
  );

  assign hsync = w_dly.hs;
  assign vsync = w_dly.vs;
  assign de    = w_dly.de;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing. Three instances share one clock:
//   u_def : default 640x480, PIPE=2, active-low syncs
//   u_p0  : PIPE=0, SYNC_POL=1
//   u_sm  : tiny raster (16x10 total) so frame wrap and mid-frame reset are reachable
// Small raster: H 8/2/3/3 (hsync hcnt 10..12), V 6/1/2/1 (vsync lines 7..8).
module tb_vga_timing;

  logic clkp = 1'b0;
  logic rst_a, rst_b;
  always #5 clkp = ~clkp;

  logic [9:0] d_x, d_y, p_x, p_y, s_x, s_y;
  logic d_req, d_ls, d_fs, d_hs, d_vs, d_de;
  logic p_req, p_ls, p_fs, p_hs, p_vs, p_de;
  logic s_req, s_ls, s_fs, s_hs, s_vs, s_de;

  vga_timing u_def (
    .clkp(clkp), .reset(rst_a), .x(d_x), .y(d_y), .req(d_req),
    .line_start(d_ls), .frame_start(d_fs), .hsync(d_hs), .vsync(d_vs), .de(d_de)
  );

  vga_timing #(.PIPE(0), .SYNC_POL(1'b1)) u_p0 (
    .clkp(clkp), .reset(rst_a), .x(p_x), .y(p_y), .req(p_req),
    .line_start(p_ls), .frame_start(p_fs), .hsync(p_hs), .vsync(p_vs), .de(p_de)
  );

  vga_timing #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
               .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_sm (
    .clkp(clkp), .reset(rst_b), .x(s_x), .y(s_y), .req(s_req),
    .line_start(s_ls), .frame_start(s_fs), .hsync(s_hs), .vsync(s_vs), .de(s_de)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkp);
    #1;
  endtask

  initial begin
    int hs_lo, hs_first, hs_last, de_hi, de_first, de_last, vs_lo, ls_cnt;
    int p_hs_hi, p_hs_first, p_hs_last, p_de_bad;
    int s_fs_cnt, s_ls_cnt, s_de_hi, s_vs_lo;

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) tick();

    // Reset state
    chk("rst_x", d_x, 0);
    chk("rst_y", d_y, 0);
    chk("rst_req", d_req, 0);
    chk("rst_ls", d_ls, 0);
    chk("rst_fs", d_fs, 0);
    chk("rst_hs", d_hs, 1);
    chk("rst_vs", d_vs, 1);
    chk("rst_de", d_de, 0);
    chk("p0_rst_hs", p_hs, 0);
    chk("p0_rst_vs", p_vs, 0);
    chk("p0_rst_de", p_de, 0);

    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    // First released cycle: counters still 0, frame starts
    chk("rel_x", d_x, 0);
    chk("rel_y", d_y, 0);
    chk("rel_fs", d_fs, 1);
    chk("rel_req", d_req, 1);
    chk("rel_de", d_de, 0);
    chk("p0_rel_de", p_de, 1);

    // Line 0 of the default raster, cycle c == hcnt
    hs_lo = 0; hs_first = -1; hs_last = -1;
    de_hi = 0; de_first = -1; de_last = -1;
    vs_lo = 0; ls_cnt = 0;
    p_hs_hi = 0; p_hs_first = -1; p_hs_last = -1; p_de_bad = 0;
    for (int c = 0; c < 800; c++) begin
      if (d_hs == 1'b0) begin
        hs_lo++;
        if (hs_first < 0) hs_first = c;
        hs_last = c;
      end
      if (d_de == 1'b1) begin
        de_hi++;
        if (de_first < 0) de_first = c;
        de_last = c;
      end
      if (d_vs == 1'b0) vs_lo++;
      if (d_ls == 1'b1) ls_cnt++;
      if (p_hs == 1'b1) begin
        p_hs_hi++;
        if (p_hs_first < 0) p_hs_first = c;
        p_hs_last = c;
      end
      if (p_de !== p_req) p_de_bad++;
      tick();
    end
    chk("l0_hs_cnt", hs_lo, 96);
    chk("l0_hs_first", hs_first, 658);
    chk("l0_hs_last", hs_last, 753);
    chk("l0_de_cnt", de_hi, 640);
    chk("l0_de_first", de_first, 2);
    chk("l0_de_last", de_last, 641);
    chk("l0_vs_lo", vs_lo, 0);
    chk("l0_ls_cnt", ls_cnt, 1);
    chk("p0_hs_cnt", p_hs_hi, 96);
    chk("p0_hs_first", p_hs_first, 656);
    chk("p0_hs_last", p_hs_last, 751);
    chk("p0_de_eq_req", p_de_bad, 0);

    // 800 cycles later: line 1 begins
    chk("l1_x", d_x, 0);
    chk("l1_y", d_y, 1);
    chk("l1_ls", d_ls, 1);
    chk("l1_fs", d_fs, 0);

    // Small raster: 800 cycles = 50 lines = 5 frames, so it is at a frame start
    chk("sm_start_x", s_x, 0);
    chk("sm_start_y", s_y, 0);
    chk("sm_start_fs", s_fs, 1);
    s_fs_cnt = 0; s_ls_cnt = 0; s_de_hi = 0; s_vs_lo = 0;
    for (int c = 0; c < 160; c++) begin
      if (c == 159) begin
        chk("sm_end_x", s_x, 15);
        chk("sm_end_y", s_y, 9);
        chk("sm_end_vs", s_vs, 1);
      end
      if (s_fs == 1'b1) s_fs_cnt++;
      if (s_ls == 1'b1) s_ls_cnt++;
      if (s_de == 1'b1) s_de_hi++;
      if (s_vs == 1'b0) s_vs_lo++;
      tick();
    end
    chk("sm_fs_cnt", s_fs_cnt, 1);
    chk("sm_ls_cnt", s_ls_cnt, 10);
    chk("sm_de_cnt", s_de_hi, 48);
    chk("sm_vs_cnt", s_vs_lo, 32);
    chk("sm_wrap_x", s_x, 0);
    chk("sm_wrap_y", s_y, 0);
    chk("sm_wrap_fs", s_fs, 1);
    chk("sm_wrap_vs", s_vs, 1);

    // Move to x=12,y=8 where both delayed syncs are asserted
    repeat (140) tick();
    chk("sm_pre_x", s_x, 12);
    chk("sm_pre_y", s_y, 8);
    chk("sm_pre_hs", s_hs, 0);
    chk("sm_pre_vs", s_vs, 0);

    rst_b = 1'b1;
    tick();
    chk("sm_rst_x", s_x, 0);
    chk("sm_rst_y", s_y, 0);
    chk("sm_rst_hs", s_hs, 1);
    chk("sm_rst_vs", s_vs, 1);
    chk("sm_rst_de", s_de, 0);
    chk("sm_rst_req", s_req, 0);
    chk("sm_rst_fs", s_fs, 0);
    chk("sm_rst_ls", s_ls, 0);

    rst_b = 1'b0;
    tick();
    chk("sm_re_fs", s_fs, 1);
    chk("sm_re_req", s_req, 1);
    chk("sm_re_hs", s_hs, 1);
    chk("sm_re_de0", s_de, 0);
    tick();
    chk("sm_re_de1", s_de, 0);
    chk("sm_re_x1", s_x, 1);
    tick();
    chk("sm_re_de2", s_de, 1);
    chk("sm_re_vs2", s_vs, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
